// File: rtl/uart_rx_ctrl.sv
// UART receive sequencing controller: start detect, mid-bit sampling,
// demux slot select / capture strobe, byte assembly and framing check.
module uart_rx_ctrl #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       tick,
  output logic [3:0] sel,
  output logic       sample_en,
  output logic       rx_line,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(OVERSAMPLE);

  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        r_state;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_rx_d;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_sel;
  logic [3:0]    r_sel_nxt;
  logic [7:0]    r_shadow;
  logic [7:0]    r_data;
  logic          r_sample_en;
  logic          r_valid;
  logic          r_ferr;
  logic          r_busy;

  logic          w_fall;
  logic          w_half;
  logic          w_full;
  logic [2:0]    w_bit_idx;
  logic [3:0]    w_sel_inc;

  assign w_fall    = r_rx_d & ~r_sync2;
  assign w_half    = tick && (r_cnt == HALF_M1);
  assign w_full    = tick && (r_cnt == FULL_M1);
  assign w_bit_idx = 3'(r_sel - 4'd1);
  assign w_sel_inc = r_sel + 4'd1;

  // Two-flop synchroniser plus delayed copy for falling-edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
    end
  end

  // Frame sequencer. A sample decision raises sample_en for one cycle
  // and queues the next slot in r_sel_nxt; sel moves on the edge that
  // ends the strobe so the demux sees a stable index while capturing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_sel       <= 4'd0;
      r_sel_nxt   <= 4'd0;
      r_shadow    <= 8'h00;
      r_data      <= 8'h00;
      r_sample_en <= 1'b0;
      r_valid     <= 1'b0;
      r_ferr      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_sample_en <= 1'b0;
      r_valid     <= 1'b0;
      r_ferr      <= 1'b0;

      if (r_sample_en) begin
        r_sel <= r_sel_nxt;
      end

      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_fall) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (w_half) begin
            r_cnt       <= '0;
            r_sample_en <= 1'b1;
            if (!r_sync2) begin
              r_state   <= S_DATA;
              r_sel_nxt <= 4'd1;
            end else begin
              r_state   <= S_IDLE;
              r_sel_nxt <= 4'd0;
              r_busy    <= 1'b0;
            end
          end else if (tick) begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_DATA: begin
          if (w_full) begin
            r_cnt                 <= '0;
            r_sample_en           <= 1'b1;
            r_shadow[w_bit_idx]   <= r_sync2;
            if (r_sel == 4'd8) begin
              r_state   <= S_STOP;
              r_sel_nxt <= 4'd9;
            end else begin
              r_sel_nxt <= w_sel_inc;
            end
          end else if (tick) begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_STOP: begin
          if (w_full) begin
            r_cnt       <= '0;
            r_sample_en <= 1'b1;
            r_state     <= S_IDLE;
            r_sel_nxt   <= 4'd0;
            r_busy      <= 1'b0;
            if (r_sync2) begin
              r_data  <= r_shadow;
              r_valid <= 1'b1;
            end else begin
              r_ferr  <= 1'b1;
            end
          end else if (tick) begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_cnt     <= '0;
          r_sel_nxt <= 4'd0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign sel       = r_sel;
  assign sample_en = r_sample_en;
  assign rx_line   = r_sync2;
  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios and random
// frames compared against a frame-level reference model.
module tb_uart_rx_ctrl;

  localparam int OS  = 16;
  localparam int DIV = 4;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic       tick;
  logic [3:0] sel;
  logic       sample_en;
  logic       rx_line;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_rx_ctrl #(.OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .tick      (tick),
    .sel       (sel),
    .sample_en (sample_en),
    .rx_line   (rx_line),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic tick_en = 1'b1;
  logic abort   = 1'b0;

  // observed events
  int   sel_q[$];
  int   val_q[$];
  int   ferr_n = 0;
  int   bad_n  = 0;

  // reference model
  int   exp_sel[$];
  int   exp_val[$];
  int   exp_ferr = 0;
  logic [7:0] exp_data = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one tick every DIV clocks, changed just after the rising edge
  initial begin
    int div = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      div = (div + 1) % DIV;
      tick = tick_en && (div == 0);
    end
  end

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (sample_en) sel_q.push_back(int'(sel));
      if (rx_valid) val_q.push_back(int'(rx_data));
      if (frame_err) ferr_n++;
      if ((rx_valid || frame_err) && !sample_en) bad_n++;
      if (rx_valid && frame_err) bad_n++;
      if (sel > 4'd9) bad_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n && !abort) begin
      @(negedge clk);
      if (tick) k++;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int idle);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (abort) break;
      rx_in = bits[i];
      wait_ticks(OS);
    end
    if (!abort && idle > 0) begin
      rx_in = 1'b1;
      wait_ticks(idle);
    end
  endtask

  // frame-level model: a real start yields slots 0..9, the stop
  // level decides between a delivered byte and a framing error
  task automatic model_frame(input logic [7:0] b, input logic stop);
    for (int k = 0; k < 10; k++) exp_sel.push_back(k);
    if (stop) begin
      exp_val.push_back(int'(b));
      exp_data = b;
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic check_model(input string tag);
    int ns;
    int nv;
    chk({tag, ".nsamp"}, sel_q.size(), exp_sel.size());
    ns = (sel_q.size() < exp_sel.size()) ? sel_q.size() : exp_sel.size();
    for (int i = 0; i < ns; i++)
      chk({tag, ".sel"}, sel_q[i], exp_sel[i]);
    chk({tag, ".nvalid"}, val_q.size(), exp_val.size());
    nv = (val_q.size() < exp_val.size()) ? val_q.size() : exp_val.size();
    for (int i = 0; i < nv; i++)
      chk({tag, ".byte"}, val_q[i], exp_val[i]);
    chk({tag, ".nferr"}, ferr_n, exp_ferr);
    chk({tag, ".rx_data"}, rx_data, exp_data);
    chk({tag, ".busy"}, busy, 1'b0);
    sel_q.delete();
    val_q.delete();
    exp_sel.delete();
    exp_val.delete();
    ferr_n = 0;
    exp_ferr = 0;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, ".sel"}, sel, 4'd0);
    chk({tag, ".sample_en"}, sample_en, 1'b0);
    chk({tag, ".rx_line"}, rx_line, 1'b1);
    chk({tag, ".rx_data"}, rx_data, 8'h00);
    chk({tag, ".rx_valid"}, rx_valid, 1'b0);
    chk({tag, ".frame_err"}, frame_err, 1'b0);
    chk({tag, ".busy"}, busy, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    logic       rs;
    logic [3:0] s0;
    int         chg;

    rst   = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst = 1'b0;
    wait_ticks(20);

    // false start with start-detect latency
    @(negedge clk);
    rx_in = 1'b0;
    @(negedge clk);
    chk("lat.clk1", busy, 1'b0);
    @(negedge clk);
    chk("lat.clk2", busy, 1'b0);
    @(negedge clk);
    chk("lat.clk3", busy, 1'b1);
    wait_ticks(5);
    rx_in = 1'b1;
    wait_ticks(OS);
    exp_sel.push_back(0);
    check_model("false_start");

    // clean frame
    send_frame(8'hA5, 1'b1, 2 * OS);
    model_frame(8'hA5, 1'b1);
    check_model("clean_a5");

    // framing error, line then held low
    send_frame(8'h3C, 1'b0, 0);
    rx_in = 1'b0;
    wait_ticks(3 * OS);
    model_frame(8'h3C, 1'b0);
    check_model("ferr_3c");
    rx_in = 1'b1;
    wait_ticks(2 * OS);

    // back-to-back frames
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 2 * OS);
    model_frame(8'h00, 1'b1);
    model_frame(8'hFF, 1'b1);
    check_model("b2b");

    // reset mid-frame
    fork
      send_frame(8'hC3, 1'b1, 0);
      begin
        for (int c = 0; c < 4000 && sel != 4'd5; c++)
          @(negedge clk);
        chk("rst.reach_sel5", sel, 4'd5);
        #1;
        rst   = 1'b1;
        abort = 1'b1;
        rx_in = 1'b1;
        #1;
        check_reset_outs("rst_mid");
      end
    join
    rx_in = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    abort = 1'b0;
    sel_q.delete();
    val_q.delete();
    ferr_n   = 0;
    exp_data = 8'h00;
    wait_ticks(2 * OS);
    check_model("post_rst");
    send_frame(8'h81, 1'b1, 2 * OS);
    model_frame(8'h81, 1'b1);
    check_model("after_rst_81");

    // tick gated off in mid-data
    chg = 0;
    fork
      send_frame(8'h5A, 1'b1, 2 * OS);
      begin
        for (int c = 0; c < 4000 && sel != 4'd3; c++)
          @(negedge clk);
        chk("gate.reach_sel3", sel, 4'd3);
        tick_en = 1'b0;
        s0 = sel;
        repeat (50) begin
          @(negedge clk);
          if (sel != s0 || sample_en || rx_valid || frame_err || !busy)
            chg++;
        end
        chk("gate.frozen", chg, 0);
        tick_en = 1'b1;
      end
    join
    model_frame(8'h5A, 1'b1);
    check_model("gated_5a");

    // random frames
    for (int f = 0; f < 6; f++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rb, rs, 2 * OS);
      model_frame(rb, rs);
      check_model("random");
    end

    chk("protocol_violations", bad_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
